// File: rtl/sarray_left_feeder_if.sv
// sarray_left_feeder_if: command, operand-stream and PE left-edge bundle of one row feeder.
interface sarray_left_feeder_if #(
    parameter int CNT_W  = 8,
    parameter int PREC_W = 3,
    parameter int DATA_W = 16
);
    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic              cmd_type_i;
    logic [PREC_W-1:0] cmd_precision_i;
    logic [CNT_W-1:0]  cmd_len_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [DATA_W-1:0] in_data_i;
    logic              left_data_valid_o;
    logic [CNT_W-1:0]  left_data_cnt_o;
    logic              left_data_type_o;
    logic [PREC_W-1:0] left_precision_o;
    logic [DATA_W-1:0] left_data_o;
    logic              busy_o;
    logic              underflow_o;

    modport master (
        output cmd_valid_i, cmd_type_i, cmd_precision_i, cmd_len_i, in_valid_i, in_data_i,
        input  cmd_ready_o, in_ready_o, left_data_valid_o, left_data_cnt_o, left_data_type_o,
               left_precision_o, left_data_o, busy_o, underflow_o
    );
    modport slave (
        input  cmd_valid_i, cmd_type_i, cmd_precision_i, cmd_len_i, in_valid_i, in_data_i,
        output cmd_ready_o, in_ready_o, left_data_valid_o, left_data_cnt_o, left_data_type_o,
               left_precision_o, left_data_o, busy_o, underflow_o
    );
endinterface

// File: rtl/sarray_left_feeder.sv
// sarray_left_feeder: per-row operand FIFO, diagonal skew and beat sequencer
// driving the left edge of column-0 PE in systolic-array row ROW.
module sarray_left_feeder #(
    parameter int ROW                  = 0,
    parameter int DEPTH                = 8,
    parameter int SARRAY_W             = 4,
    parameter int TMMA_CNT_WIDTH       = 8,
    parameter int TMMA_PRECISION_WIDTH = 3,
    parameter int PE_INPUT_DATA_WIDTH  = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    sarray_left_feeder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = (ROW > 1) ? $clog2(ROW) : 1;
    typedef enum logic {PE_DATA_TYPE_A = 1'b0, PE_DATA_TYPE_C = 1'b1} pe_data_type_e;
    typedef enum logic [1:0] {IDLE, SKEW, STREAM} state_e;

    state_e                          r_state;
    logic [PE_INPUT_DATA_WIDTH-1:0]  r_mem [DEPTH];
    logic [AW-1:0]                   r_wp, r_rp;
    logic [AW:0]                     r_count;
    logic [SW-1:0]                   r_skew;
    logic [TMMA_CNT_WIDTH-1:0]       r_beats, r_idx, r_cnt;
    logic                            r_type, r_out_type, r_valid;
    logic [TMMA_PRECISION_WIDTH-1:0] r_prec, r_out_prec;
    logic [PE_INPUT_DATA_WIDTH-1:0]  r_data;
    logic                            w_push, w_pop, w_empty, w_type_a;
    logic [TMMA_CNT_WIDTH-1:0]       w_beats;

    // DEPTH is a power of two, so count MSB set means exactly full
    assign w_empty  = r_count == '0;
    assign w_push   = bus.in_valid_i && !r_count[AW];
    assign w_pop    = r_state == STREAM && !w_empty;
    assign w_type_a = bus.cmd_type_i == PE_DATA_TYPE_A;
    assign w_beats  = w_type_a ? bus.cmd_len_i : TMMA_CNT_WIDTH'(SARRAY_W);

    always_ff @(posedge clk)
        if (w_push) r_mem[r_wp] <= bus.in_data_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            r_wp    <= w_push ? r_wp + 1'b1 : r_wp;
            r_rp    <= w_pop ? r_rp + 1'b1 : r_rp;
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_skew     <= '0;
            r_beats    <= '0;
            r_idx      <= '0;
            r_type     <= 1'b0;
            r_prec     <= '0;
            r_valid    <= 1'b0;
            r_cnt      <= '0;
            r_out_type <= 1'b0;
            r_out_prec <= '0;
            r_data     <= '0;
        end else begin
            r_valid <= w_pop;
            case (r_state)
                IDLE: if (bus.cmd_valid_i) begin
                    r_type  <= bus.cmd_type_i;
                    r_prec  <= bus.cmd_precision_i;
                    r_beats <= w_beats;
                    r_idx   <= '0;
                    r_skew  <= SW'((ROW > 0) ? ROW - 1 : 0);
                    r_state <= (w_beats == '0) ? IDLE : ((ROW > 0) ? SKEW : STREAM);
                end
                SKEW: begin
                    r_skew  <= r_skew - 1'b1;
                    r_state <= (r_skew == '0) ? STREAM : SKEW;
                end
                STREAM: if (w_pop) begin
                    // C beats count 1..SARRAY_W so the first word reaches the farthest column
                    r_cnt      <= (r_type == PE_DATA_TYPE_A) ? r_idx : r_idx + 1'b1;
                    r_out_type <= r_type;
                    r_out_prec <= r_prec;
                    r_data     <= r_mem[r_rp];
                    r_idx      <= r_idx + 1'b1;
                    r_state    <= (r_idx == r_beats - 1'b1) ? IDLE : STREAM;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready_o       = r_state == IDLE;
    assign bus.busy_o            = r_state != IDLE;
    assign bus.underflow_o       = r_state == STREAM && w_empty;
    assign bus.in_ready_o        = !r_count[AW];
    assign bus.left_data_valid_o = r_valid;
    assign bus.left_data_cnt_o   = r_cnt;
    assign bus.left_data_type_o  = r_out_type;
    assign bus.left_precision_o  = r_out_prec;
    assign bus.left_data_o       = r_data;
endmodule

// File: tb/tb_sarray_left_feeder.sv
// tb_sarray_left_feeder: drives a ROW=0 and a ROW=3 feeder with identical traffic and
// checks every cycle against a pop-schedule model derived from availability and skew.
module tb_sarray_left_feeder;
    localparam int DEPTH = 8, SW = 4, CW = 8, PW = 3, DW = 16;
    localparam logic TA = 1'b0, TC = 1'b1;

    typedef struct {
        logic          t;
        logic [PW-1:0] p;
        int            len;
        int            npre;
        int            nlate;
        int            late0;
        int            exp_beats;
        string         nm;
    } vec_t;

    typedef struct packed {
        logic          v;
        logic [CW-1:0] c;
        logic          t;
        logic [PW-1:0] p;
        logic [DW-1:0] x;
        logic          busy;
        logic          uf;
        logic          cr;
        logic          ir;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_vec = 0;
    int n_err = 0;
    bit rnd = 1'b0;
    logic [DW-1:0] seq = '0;
    logic [DW-1:0] wq[$];
    int rows[2] = '{0, 3};
    vec_t tbl[9];

    always #5 clk = ~clk;

    sarray_left_feeder_if #(.CNT_W(CW), .PREC_W(PW), .DATA_W(DW)) b0 ();
    sarray_left_feeder_if #(.CNT_W(CW), .PREC_W(PW), .DATA_W(DW)) b3 ();

    sarray_left_feeder #(.ROW(0), .DEPTH(DEPTH), .SARRAY_W(SW), .TMMA_CNT_WIDTH(CW),
        .TMMA_PRECISION_WIDTH(PW), .PE_INPUT_DATA_WIDTH(DW)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    sarray_left_feeder #(.ROW(3), .DEPTH(DEPTH), .SARRAY_W(SW), .TMMA_CNT_WIDTH(CW),
        .TMMA_PRECISION_WIDTH(PW), .PE_INPUT_DATA_WIDTH(DW)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3));

    function automatic int mx(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic obs_t get(input int i);
        obs_t o;
        if (i == 0)
            o = {b0.left_data_valid_o, b0.left_data_cnt_o, b0.left_data_type_o, b0.left_precision_o,
                 b0.left_data_o, b0.busy_o, b0.underflow_o, b0.cmd_ready_o, b0.in_ready_o};
        else
            o = {b3.left_data_valid_o, b3.left_data_cnt_o, b3.left_data_type_o, b3.left_precision_o,
                 b3.left_data_o, b3.busy_o, b3.underflow_o, b3.cmd_ready_o, b3.in_ready_o};
        return o;
    endfunction

    function automatic logic [DW-1:0] next_word();
        if (rnd) return DW'($urandom);
        seq = seq + 16'h11;
        return seq;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic v, input logic [DW-1:0] w);
        b0.in_valid_i = v; b0.in_data_i = w;
        b3.in_valid_i = v; b3.in_data_i = w;
    endtask

    task automatic set_cmd(input logic v, input logic t, input logic [PW-1:0] p, input logic [CW-1:0] l);
        b0.cmd_valid_i = v; b0.cmd_type_i = t; b0.cmd_precision_i = p; b0.cmd_len_i = l;
        b3.cmd_valid_i = v; b3.cmd_type_i = t; b3.cmd_precision_i = p; b3.cmd_len_i = l;
    endtask

    task automatic push_word();
        logic [DW-1:0] w;
        int k;
        k = 0;
        while (!(b0.in_ready_o && b3.in_ready_o) && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k == 100) begin
            n_vec++; n_err++;
            $display("FAIL push_wait: in_ready stayed low for 100 cycles");
        end else begin
            w = next_word();
            set_in(1'b1, w);
            @(negedge clk);
            set_in(1'b0, '0);
            wq.push_back(w);
        end
    endtask

    task automatic issue(input logic t, input logic [PW-1:0] p, input int len);
        int k;
        k = 0;
        while (!(b0.cmd_ready_o && b3.cmd_ready_o) && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k == 200) begin
            n_vec++; n_err++;
            $display("FAIL issue_wait: cmd_ready stayed low for 200 cycles");
        end
        set_cmd(1'b1, t, p, CW'(len));
        @(negedge clk);
        set_cmd(1'b0, TA, '0, '0);
    endtask

    // Beat k leaves the FIFO at the earliest cycle that follows the previous pop, finds
    // word k already stored and lies past the skew; j counts cycles after the handshake.
    task automatic run_cmd(input vec_t v);
        int beats, lvl0, nlate, jmax, pushed, k, npb, pend;
        int last[2];
        int seen[2];
        int pop[2][16];
        int avail[16];
        bit popj, is_push;
        obs_t o;
        logic [DW-1:0] w;
        beats = (v.t == TC) ? SW : v.len;
        for (int i = 0; i < v.npre; i++) push_word();
        lvl0 = wq.size();
        nlate = (lvl0 + v.nlate < beats) ? beats - lvl0 : v.nlate;
        for (int i = 0; i < beats; i++) avail[i] = (i < lvl0) ? -100 : v.late0 + (i - lvl0) + 1;
        for (int d = 0; d < 2; d++) begin
            pend = -1;
            for (int i = 0; i < beats; i++) begin
                pend = mx(mx(pend + 1, avail[i]), rows[d]);
                pop[d][i] = pend;
            end
            last[d] = pend;
            seen[d] = 0;
        end
        jmax = mx(mx(last[1] + 2, v.late0 + nlate + 1), 4);
        issue(v.t, v.p, v.len);
        pushed = 0;
        for (int j = 0; j <= jmax; j++) begin
            is_push = j >= v.late0 && j < v.late0 + nlate;
            if (is_push) begin
                w = next_word();
                set_in(1'b1, w);
                wq.push_back(w);
            end else set_in(1'b0, '0);
            for (int d = 0; d < 2; d++) begin
                o = get(d);
                k = -1; popj = 1'b0; npb = 0;
                for (int i = 0; i < beats; i++) begin
                    if (pop[d][i] + 1 == j) k = i;
                    if (pop[d][i] == j) popj = 1'b1;
                    if (pop[d][i] < j) npb++;
                end
                chk($sformatf("%s r%0d j%0d valid", v.nm, rows[d], j), 32'(o.v), 32'(k >= 0));
                if (k >= 0) begin
                    seen[d]++;
                    chk($sformatf("%s r%0d j%0d data", v.nm, rows[d], j), 32'(o.x), 32'(wq[k]));
                    chk($sformatf("%s r%0d j%0d cnt", v.nm, rows[d], j), 32'(o.c), (v.t == TA) ? k : k + 1);
                    chk($sformatf("%s r%0d j%0d type", v.nm, rows[d], j), 32'(o.t), 32'(v.t));
                    chk($sformatf("%s r%0d j%0d prec", v.nm, rows[d], j), 32'(o.p), 32'(v.p));
                end
                chk($sformatf("%s r%0d j%0d underflow", v.nm, rows[d], j), 32'(o.uf),
                    32'(j >= rows[d] && j <= last[d] && !popj));
                chk($sformatf("%s r%0d j%0d busy", v.nm, rows[d], j), 32'(o.busy), 32'(j <= last[d]));
                chk($sformatf("%s r%0d j%0d cmd_ready", v.nm, rows[d], j), 32'(o.cr), 32'(j > last[d]));
                chk($sformatf("%s r%0d j%0d in_ready", v.nm, rows[d], j), 32'(o.ir),
                    32'(lvl0 + pushed - npb < DEPTH));
            end
            if (is_push) pushed++;
            @(negedge clk);
        end
        set_in(1'b0, '0);
        for (int d = 0; d < 2; d++)
            chk($sformatf("%s r%0d beat_count", v.nm, rows[d]), seen[d], v.exp_beats);
        repeat (beats) void'(wq.pop_front());
    endtask

    task automatic chk_reset(input string nm);
        obs_t o;
        for (int d = 0; d < 2; d++) begin
            o = get(d);
            chk($sformatf("%s r%0d left_outputs", nm, rows[d]), 32'({o.v, o.c, o.t, o.p, o.x}), 32'd0);
            chk($sformatf("%s r%0d busy", nm, rows[d]), 32'(o.busy), 32'd0);
            chk($sformatf("%s r%0d underflow", nm, rows[d]), 32'(o.uf), 32'd0);
            chk($sformatf("%s r%0d cmd_ready", nm, rows[d]), 32'(o.cr), 32'd1);
            chk($sformatf("%s r%0d in_ready", nm, rows[d]), 32'(o.ir), 32'd1);
        end
    endtask

    task automatic drain();
        vec_t v;
        if (wq.size() > 0) begin
            v = '{TA, 3'd0, wq.size(), 0, 0, 0, wq.size(), "drain"};
            run_cmd(v);
        end
    endtask

    initial begin
        vec_t v;
        int l;
        obs_t o;
        tbl[0] = '{TA, 3'd1, 3, 3, 0, 0, 3, "basic_a"};
        tbl[1] = '{TA, 3'd2, 2, 2, 0, 0, 2, "skew"};
        tbl[2] = '{TC, 3'd5, 9, 4, 0, 0, 4, "c_preload"};
        tbl[3] = '{TA, 3'd0, 4, 2, 2, 3, 4, "underflow"};
        tbl[4] = '{TA, 3'd3, 0, 1, 0, 0, 0, "zero_len"};
        tbl[5] = '{TA, 3'd6, 3, 3, 0, 0, 3, "leftover"};
        tbl[6] = '{TC, 3'd7, 0, 3, 0, 0, 4, "c_len0"};
        tbl[7] = '{TA, 3'd4, 1, 0, 1, 0, 1, "late_single"};
        tbl[8] = '{TA, 3'd2, DEPTH, DEPTH, 0, 0, DEPTH, "fill_depth"};
        set_in(1'b0, '0);
        set_cmd(1'b0, TA, '0, '0);
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst_n = 1'b1;
        @(negedge clk);
        foreach (tbl[i]) run_cmd(tbl[i]);

        // overfill from IDLE: only DEPTH words may be taken
        drain();
        for (int i = 0; i < DEPTH + 2; i++) begin
            for (int d = 0; d < 2; d++) begin
                o = get(d);
                chk($sformatf("fill r%0d push%0d in_ready", rows[d], i), 32'(o.ir), 32'(i < DEPTH));
            end
            v.p = '0;
            seq = next_word();
            set_in(1'b1, seq);
            if (i < DEPTH) wq.push_back(seq);
            @(negedge clk);
        end
        set_in(1'b0, '0);
        v = '{TA, 3'd3, DEPTH, 0, 0, 0, DEPTH, "full_drain"};
        run_cmd(v);

        // asynchronous reset in the middle of a five-beat stream
        drain();
        for (int i = 0; i < 5; i++) push_word();
        issue(TA, 3'd6, 5);
        repeat (2) @(negedge clk);
        o = get(0);
        chk("mid_reset r0 beat2 valid", 32'(o.v), 32'd1);
        chk("mid_reset r0 beat2 cnt", 32'(o.c), 32'd1);
        #1 rst_n = 1'b0;
        #1 chk_reset("mid_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wq.delete();
        @(negedge clk);
        chk_reset("post_reset_idle");
        v = '{TA, 3'd5, 1, 1, 0, 0, 1, "post_reset"};
        run_cmd(v);

        rnd = 1'b1;
        for (int i = 0; i < 30; i++) begin
            l = wq.size();
            v.t = 1'($urandom_range(0, 1));
            v.p = PW'($urandom);
            v.len = $urandom_range(0, DEPTH);
            v.npre = $urandom_range(0, DEPTH - l);
            v.nlate = $urandom_range(0, 3);
            if (l + v.npre + v.nlate > DEPTH) v.nlate = DEPTH - l - v.npre;
            v.late0 = $urandom_range(0, 6);
            v.exp_beats = (v.t == TC) ? SW : v.len;
            v.nm = $sformatf("rand%0d", i);
            run_cmd(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
